// File: rtl/muldiv_pkg.sv
// Shared ALU control codes and the HI/LO sequencer state encoding.
// The ALU decoder uses the same control codes.
package muldiv_pkg;

    localparam logic [3:0] ALU_MUL  = 4'b1111;
    localparam logic [3:0] ALU_DIV  = 4'b1110;
    localparam logic [3:0] ALU_MFHI = 4'b0011;
    localparam logic [3:0] ALU_MFLO = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] c);
        return (c == ALU_MUL) || (c == ALU_DIV);
    endfunction

    function automatic logic is_mfx(input logic [3:0] c);
        return (c == ALU_MFHI) || (c == ALU_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// The accumulator is {upper, lower}, and each half is WIDTH bits.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  state_t               mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] addend;

    // Multiply: add the multiplicand on a set LSB, then shift right with carry.
    // Divide: shift the remainder left, then subtract the divisor if it fits.
    always_comb begin
        addend   = acc[0] ? opnd : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        trial    = acc[2*WIDTH-1:WIDTH-1];
        diff     = trial[WIDTH-1:0] - opnd;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (mode == DIV) begin
            if (trial >= {1'b0, opnd})
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for MULT/DIV/MFHI/MFLO in the EX stage.
// Multiply and divide iterate one step per cycle and stall dependent ops.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, state_n;
    logic [CW-1:0]      count, count_n;
    logic [2*WIDTH-1:0] acc, acc_n, step_out;
    logic [WIDTH-1:0]   rb, rb_n;
    logic [WIDTH-1:0]   hi, hi_n;
    logic [WIDTH-1:0]   lo, lo_n;
    logic               dbz_n, done_n;
    logic               start, last;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (state),
        .acc      (acc),
        .opnd     (rb),
        .acc_next (step_out)
    );

    assign busy  = (state != IDLE);
    assign stall = in_valid && busy
                && (is_muldiv(alu_ctrl) || is_mfx(alu_ctrl));
    assign start = in_valid && !busy && is_muldiv(alu_ctrl);
    assign last  = (count == CW'(WIDTH - 1));

    // Next-state logic: flush beats completion, and a start with flush is dropped.
    always_comb begin
        state_n = state;
        count_n = count;
        acc_n   = acc;
        rb_n    = rb;
        hi_n    = hi;
        lo_n    = lo;
        dbz_n   = div_by_zero;
        done_n  = 1'b0;
        if (flush) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dbz_n   = 1'b0;
                        count_n = '0;
                        rb_n    = b;
                        acc_n   = {{WIDTH{1'b0}}, a};
                        if (alu_ctrl == ALU_DIV && b == '0) begin
                            hi_n   = a;
                            lo_n   = '1;
                            dbz_n  = 1'b1;
                            done_n = 1'b1;
                        end else if (alu_ctrl == ALU_MUL) begin
                            state_n = MUL;
                        end else begin
                            state_n = DIV;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_n   = step_out;
                    count_n = count + CW'(1);
                    if (last) begin
                        state_n      = IDLE;
                        count_n      = '0;
                        {hi_n, lo_n} = step_out;
                        done_n       = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            rb          <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            acc         <= acc_n;
            rb          <= rb_n;
            hi          <= hi_n;
            lo          <= lo_n;
            div_by_zero <= dbz_n;
            done        <= done_n;
        end
    end

    // MFHI/MFLO read path; it returns zero while the unit is busy.
    always_comb begin
        result = '0;
        unique case (1'b1)
            in_valid && !busy && alu_ctrl == ALU_MFHI: result = hi;
            in_valid && !busy && alu_ctrl == ALU_MFLO: result = lo;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl.
// Expected HI/LO values come from plain arithmetic on operands.
module tb_hilo_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic [W-1:0] result;
    logic         stall;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic         m_dbz;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .alu_ctrl    (alu_ctrl),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .result      (result),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic model_op(input logic [3:0] op, input logic [W-1:0] x,
                            input logic [W-1:0] y, output int cyc);
        logic [2*W-1:0] p;
        if (op == ALU_MUL) begin
            p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            m_hi  = p[2*W-1:W];
            m_lo  = p[W-1:0];
            m_dbz = 1'b0;
            cyc   = W;
        end else if (y == '0) begin
            m_hi  = x;
            m_lo  = '1;
            m_dbz = 1'b1;
            cyc   = 0;
        end else begin
            m_hi  = x % y;
            m_lo  = x / y;
            m_dbz = 1'b0;
            cyc   = W;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = op;
        a        = x;
        b        = y;
        @(negedge clk);
        in_valid = 1'b0;
        alu_ctrl = 4'h0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
        in_valid = 1'b1;
        alu_ctrl = ALU_MFHI;
        #1 h = result;
        alu_ctrl = ALU_MFLO;
        #1 l = result;
        in_valid = 1'b0;
        alu_ctrl = 4'h0;
    endtask

    task automatic test_reset();
        logic [W-1:0] h, l;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        alu_ctrl = 4'h0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b dbz=%b expected 0 0 0",
                     busy, done, div_by_zero);
        end
        read_hilo(h, l);
        checks++;
        if (h !== '0 || l !== '0) begin
            errors++;
            $display("FAIL reset_hilo got %h/%h expected 0/0", h, l);
        end
    endtask

    task automatic test_op(input logic [3:0] op, input logic [W-1:0] x,
                           input logic [W-1:0] y, input string name);
        int exp_cyc, n;
        logic [W-1:0] h, l;
        model_op(op, x, y, exp_cyc);
        issue(op, x, y);
        wait_idle(n);
        checks++;
        if (n !== exp_cyc) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d", name, n, exp_cyc);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done got %b expected 1", name, done);
        end
        read_hilo(h, l);
        checks++;
        if (h !== m_hi) begin
            errors++;
            $display("FAIL %s hi got %h expected %h", name, h, m_hi);
        end
        checks++;
        if (l !== m_lo) begin
            errors++;
            $display("FAIL %s lo got %h expected %h", name, l, m_lo);
        end
        checks++;
        if (div_by_zero !== m_dbz) begin
            errors++;
            $display("FAIL %s dbz got %b expected %b", name, div_by_zero, m_dbz);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse got %b expected 0", name, done);
        end
    endtask

    task automatic test_stall();
        int exp_cyc, n;
        logic [W-1:0] l;
        model_op(ALU_MUL, 3, 4, exp_cyc);
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = ALU_MUL; a = 3; b = 4;
        @(negedge clk);
        alu_ctrl = ALU_MFHI;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            checks++;
            if (stall !== 1'b1 || result !== '0) begin
                errors++;
                $display("FAIL stall_busy got stall=%b result=%h expected 1/0",
                         stall, result);
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== exp_cyc) begin
            errors++;
            $display("FAIL stall_cycles got %0d expected %0d", n, exp_cyc);
        end
        checks++;
        if (stall !== 1'b0 || done !== 1'b1 || result !== m_hi) begin
            errors++;
            $display("FAIL stall_done got stall=%b done=%b hi=%h expected 0 1 %h",
                     stall, done, result, m_hi);
        end
        alu_ctrl = ALU_MFLO;
        #1 l = result;
        in_valid = 1'b0; alu_ctrl = 4'h0;
        checks++;
        if (l !== m_lo) begin
            errors++;
            $display("FAIL stall_lo got %h expected %h", l, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        int exp_cyc, n;
        logic [W-1:0] x, y, h, l;
        x = $urandom; y = $urandom;
        model_op(ALU_MUL, x, y, exp_cyc);
        issue(ALU_MUL, x, y);
        in_valid = 1'b1; a = $urandom; b = $urandom;
        alu_ctrl = ALU_MUL;
        #1 checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_mul_stall got %b expected 1", stall);
        end
        alu_ctrl = 4'b0010;
        #1 checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_other_stall got %b expected 0", stall);
        end
        alu_ctrl = ALU_MFLO;
        #1 checks++;
        if (stall !== 1'b1 || result !== '0) begin
            errors++;
            $display("FAIL b2b_mflo got stall=%b result=%h expected 1/0",
                     stall, result);
        end
        alu_ctrl = ALU_DIV;
        repeat (5) @(negedge clk);
        in_valid = 1'b0; alu_ctrl = 4'h0;
        wait_idle(n);
        checks++;
        if (n !== exp_cyc - 5) begin
            errors++;
            $display("FAIL b2b_cycles got %0d expected %0d", n, exp_cyc - 5);
        end
        read_hilo(h, l);
        checks++;
        if (h !== m_hi || l !== m_lo) begin
            errors++;
            $display("FAIL b2b_hilo got %h/%h expected %h/%h", h, l, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] h, l;
        issue(ALU_MUL, 9, 9);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got busy=%b done=%b expected 0 0", busy, done);
        end
        read_hilo(h, l);
        checks++;
        if (h !== '0 || l !== '0) begin
            errors++;
            $display("FAIL rst_mid_hilo got %h/%h expected 0/0", h, l);
        end
    endtask

    task automatic test_flush();
        int seen;
        logic [W-1:0] h, l;
        test_op(ALU_DIV, 7395, 86, "div_55");
        issue(ALU_MUL, 9, 9);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_mid busy got %b expected 0", busy);
        end
        seen = 0;
        repeat (40) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_mid_done got %0d pulses expected 0", seen);
        end
        issue(ALU_MUL, 2, 3);
        repeat (W - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_last got busy=%b done=%b expected 0 0", busy, done);
        end
        flush = 1'b1; in_valid = 1'b1; alu_ctrl = ALU_MUL; a = 1; b = 1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; alu_ctrl = 4'h0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_start got busy=%b done=%b expected 0 0", busy, done);
        end
        read_hilo(h, l);
        checks++;
        if (h !== 32'h55 || l !== 32'h55 || div_by_zero !== m_dbz) begin
            errors++;
            $display("FAIL flush_hilo got %h/%h dbz=%b expected 55/55 dbz=%b",
                     h, l, div_by_zero, m_dbz);
        end
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] x, y;
        int sel;
        for (int i = 0; i < 10; i++) begin
            op  = ($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_DIV;
            x   = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       y = '0;
                1:       y = W'($urandom_range(1, 255));
                default: y = $urandom;
            endcase
            test_op(op, x, y, "random");
        end
    endtask

    initial begin
        test_reset();
        test_op(ALU_MUL, 7, 6, "mul_7_6");
        test_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        test_op(ALU_DIV, 100, 7, "div_100_7");
        test_op(ALU_DIV, 5, 0, "div_by_zero");
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
